// File: rtl/ppu_regs_pkg.sv
// Register-select encoding, status/CTRL bit positions and VRAM address steps
// shared by the PPU CPU-side register bridge.
package ppu_regs_pkg;

  typedef enum logic [2:0] {
    CTRL    = 3'd0,
    MASK    = 3'd1,
    STATUS  = 3'd2,
    OAMADDR = 3'd3,
    OAMDATA = 3'd4,
    SCROLL  = 3'd5,
    ADDR    = 3'd6,
    DATA    = 3'd7
  } reg_sel_e;

  localparam int unsigned STAT_VBLANK = 7;
  localparam int unsigned STAT_SPR0   = 6;
  localparam int unsigned STAT_OVF    = 5;

  localparam int unsigned CTRL_INC32  = 2;
  localparam int unsigned CTRL_NMI_EN = 7;

  localparam int unsigned VINC_ACROSS = 1;
  localparam int unsigned VINC_DOWN   = 32;

  // Low five bits of a status read come from whatever was last on the bus.
  function automatic logic [7:0] status_byte(input logic vbl, input logic spr0,
                                             input logic ovf, input logic [7:0] openbus);
    logic [7:0] s;
    s              = {3'b000, openbus[4:0]};
    s[STAT_VBLANK] = vbl;
    s[STAT_SPR0]   = spr0;
    s[STAT_OVF]    = ovf;
    return s;
  endfunction

endpackage

// File: rtl/ppu_access_strobe.sv
// Chip-select edge detector: one acc_stb per CPU access however long cs_n stays low,
// plus the read-data drive window that stays open until cs_n is sampled high.
module ppu_access_strobe (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cs_n_i,
  input  logic rw_i,
  output logic acc_stb_o,
  output logic rdata_oe_o
);

  logic cs_n_q;
  logic oe_q, oe_d;

  // cs_n_q resets low, so a select held low across reset never produces a strobe.
  assign acc_stb_o  = ~cs_n_i & cs_n_q;
  assign rdata_oe_o = oe_q;

  always_comb begin
    oe_d = oe_q;
    if (acc_stb_o && rw_i) begin
      oe_d = 1'b1;
    end else if (cs_n_i) begin
      oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_n_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      cs_n_q <= cs_n_i;
      oe_q   <= oe_d;
    end
  end

endmodule

// File: rtl/ppu_cpu_reg_bridge.sv
// Clocked CPU/PPU register bridge: register file, VRAM/OAM port strobes, status and NMI.
// Define PPU_OPEN_BUS_DECAY_EN to let the open-bus latch decay to zero after DECAY_W-bit idle time.
module ppu_cpu_reg_bridge
  import ppu_regs_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned VADDR_W = 14,
  parameter int unsigned DECAY_W = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   cpu_addr,
  input  logic               cpu_cs_n,
  input  logic               cpu_rw,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_rdata_oe,
  output logic [7:0]         ctrl_q,
  output logic [7:0]         mask_q,
  output logic [7:0]         scroll_x_q,
  output logic [7:0]         scroll_y_q,
  output logic [7:0]         oam_addr_q,
  output logic               oam_wr_stb,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata,
  output logic [VADDR_W-1:0] vram_addr_q,
  output logic               vram_rd_stb,
  output logic               vram_wr_stb,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic               vblank_q,
  output logic               nmi
);

  logic acc_stb, wr, rd;
  reg_sel_e sel;

  ppu_access_strobe u_strobe (
    .clk_i      (clk),
    .reset_i    (reset),
    .cs_n_i     (cpu_cs_n),
    .rw_i       (cpu_rw),
    .acc_stb_o  (acc_stb),
    .rdata_oe_o (cpu_rdata_oe)
  );

  assign wr  = acc_stb & ~cpu_rw;
  assign rd  = acc_stb & cpu_rw;
  assign sel = reg_sel_e'(cpu_addr[2:0]);

  if (SEL_W > 3) begin : g_mirror
    logic unused_sel_hi;
    assign unused_sel_hi = ^cpu_addr[SEL_W-1:3];
  end

  logic [7:0] ctrl_d, mask_d, scroll_x_d, scroll_y_d, oam_addr_d;
  logic [VADDR_W-1:0] vram_addr_d, vinc;
  logic       vblank_d;
  logic       w_q, w_d;
  logic [5:0] t_hi_q, t_hi_d;
  logic [7:0] rbuf_q, rbuf_d;
  logic [7:0] openbus_q, openbus_d;
  logic [7:0] rdata_q, rdata_d;
  logic       oam_wr_stb_q, oam_wr_stb_d;
  logic [7:0] oam_wdata_q, oam_wdata_d;
  logic       vram_wr_stb_q, vram_wr_stb_d;
  logic [7:0] vram_wdata_q, vram_wdata_d;
  logic       vram_rd_stb_q, vram_rd_stb_d;
  logic       rd_pend_q, rd_pend_d;
  logic       decay_hit;

  assign vinc = ctrl_q[CTRL_INC32] ? VADDR_W'(VINC_DOWN) : VADDR_W'(VINC_ACROSS);

  always_comb begin
    ctrl_d        = ctrl_q;
    mask_d        = mask_q;
    scroll_x_d    = scroll_x_q;
    scroll_y_d    = scroll_y_q;
    oam_addr_d    = oam_addr_q;
    vram_addr_d   = vram_addr_q;
    w_d           = w_q;
    t_hi_d        = t_hi_q;
    rbuf_d        = rbuf_q;
    openbus_d     = openbus_q;
    rdata_d       = rdata_q;
    oam_wr_stb_d  = 1'b0;
    oam_wdata_d   = oam_wdata_q;
    vram_wr_stb_d = 1'b0;
    vram_wdata_d  = vram_wdata_q;
    vram_rd_stb_d = 1'b0;
    rd_pend_d     = vram_rd_stb_q;

    // Post-increments land the cycle after the strobe, so the port sees the old address.
    if (oam_wr_stb_q) oam_addr_d = oam_addr_q + 8'd1;
    if (vram_wr_stb_q || vram_rd_stb_q) vram_addr_d = vram_addr_q + vinc;
    if (rd_pend_q) rbuf_d = vram_rdata;

    if (wr) begin
      openbus_d = cpu_wdata;
      unique case (sel)
        CTRL:    ctrl_d     = cpu_wdata;
        MASK:    mask_d     = cpu_wdata;
        OAMADDR: oam_addr_d = cpu_wdata;
        OAMDATA: begin
          oam_wr_stb_d = 1'b1;
          oam_wdata_d  = cpu_wdata;
        end
        SCROLL: begin
          if (w_q) scroll_y_d = cpu_wdata;
          else     scroll_x_d = cpu_wdata;
          w_d = ~w_q;
        end
        ADDR: begin
          if (!w_q) begin
            t_hi_d = cpu_wdata[5:0];
            w_d    = 1'b1;
          end else begin
            vram_addr_d = VADDR_W'({t_hi_q, cpu_wdata});
            w_d         = 1'b0;
          end
        end
        DATA: begin
          vram_wr_stb_d = 1'b1;
          vram_wdata_d  = cpu_wdata;
        end
        default: ;
      endcase
    end

    if (rd) begin
      unique case (sel)
        STATUS: begin
          rdata_d = status_byte(vblank_q, spr0_hit, spr_ovf, openbus_q);
          w_d     = 1'b0;
        end
        OAMDATA: rdata_d = oam_rdata;
        DATA: begin
          // Forward a fetch landing this cycle so back-to-back reads never see a stale buffer.
          rdata_d       = rd_pend_q ? vram_rdata : rbuf_q;
          vram_rd_stb_d = 1'b1;
        end
        default: rdata_d = openbus_q;
      endcase
      openbus_d = rdata_d;
    end

    if (decay_hit && !acc_stb) openbus_d = 8'h00;

    // Clear beats a status read, which beats a same-cycle set (the set is swallowed).
    if (vblank_clr)                 vblank_d = 1'b0;
    else if (rd && sel == STATUS)   vblank_d = 1'b0;
    else if (vblank_set)            vblank_d = 1'b1;
    else                            vblank_d = vblank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      mask_q        <= '0;
      scroll_x_q    <= '0;
      scroll_y_q    <= '0;
      oam_addr_q    <= '0;
      vram_addr_q   <= '0;
      vblank_q      <= 1'b0;
      w_q           <= 1'b0;
      t_hi_q        <= '0;
      rbuf_q        <= '0;
      openbus_q     <= '0;
      rdata_q       <= '0;
      oam_wr_stb_q  <= 1'b0;
      oam_wdata_q   <= '0;
      vram_wr_stb_q <= 1'b0;
      vram_wdata_q  <= '0;
      vram_rd_stb_q <= 1'b0;
      rd_pend_q     <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      mask_q        <= mask_d;
      scroll_x_q    <= scroll_x_d;
      scroll_y_q    <= scroll_y_d;
      oam_addr_q    <= oam_addr_d;
      vram_addr_q   <= vram_addr_d;
      vblank_q      <= vblank_d;
      w_q           <= w_d;
      t_hi_q        <= t_hi_d;
      rbuf_q        <= rbuf_d;
      openbus_q     <= openbus_d;
      rdata_q       <= rdata_d;
      oam_wr_stb_q  <= oam_wr_stb_d;
      oam_wdata_q   <= oam_wdata_d;
      vram_wr_stb_q <= vram_wr_stb_d;
      vram_wdata_q  <= vram_wdata_d;
      vram_rd_stb_q <= vram_rd_stb_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

`ifdef PPU_OPEN_BUS_DECAY_EN
  logic [DECAY_W-1:0] decay_q, decay_d;

  assign decay_hit = &decay_q;

  // Every access rewrites the latch, so every access restarts the idle count.
  always_comb begin
    decay_d = decay_q;
    if (acc_stb)         decay_d = '0;
    else if (!decay_hit) decay_d = decay_q + DECAY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) decay_q <= '0;
    else       decay_q <= decay_d;
  end
`else
  logic unused_decay_w;
  assign decay_hit      = 1'b0;
  assign unused_decay_w = ^DECAY_W;
`endif

  assign cpu_rdata   = rdata_q;
  assign oam_wr_stb  = oam_wr_stb_q;
  assign oam_wdata   = oam_wdata_q;
  assign vram_wr_stb = vram_wr_stb_q;
  assign vram_wdata  = vram_wdata_q;
  assign vram_rd_stb = vram_rd_stb_q;
  assign nmi         = vblank_q & ctrl_q[CTRL_NMI_EN];

endmodule

// File: tb/tb_ppu_cpu_reg_bridge.sv
// Randomised bench for ppu_cpu_reg_bridge against an architectural model of the PPU registers.
module tb_ppu_cpu_reg_bridge;

  localparam int SEL_W   = 3;
  localparam int VADDR_W = 14;
  localparam int DECAY_W = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [SEL_W-1:0]   cpu_addr;
  logic               cpu_cs_n, cpu_rw;
  logic [7:0]         cpu_wdata, cpu_rdata;
  logic               cpu_rdata_oe;
  logic [7:0]         ctrl_q, mask_q, scroll_x_q, scroll_y_q, oam_addr_q;
  logic               oam_wr_stb;
  logic [7:0]         oam_wdata, oam_rdata;
  logic [VADDR_W-1:0] vram_addr_q;
  logic               vram_rd_stb, vram_wr_stb;
  logic [7:0]         vram_wdata, vram_rdata;
  logic               vblank_set, vblank_clr, spr0_hit, spr_ovf, vblank_q, nmi;

  always #5 clk = ~clk;

  ppu_cpu_reg_bridge #(.SEL_W(SEL_W), .VADDR_W(VADDR_W), .DECAY_W(DECAY_W)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdata_oe(cpu_rdata_oe),
    .ctrl_q(ctrl_q), .mask_q(mask_q), .scroll_x_q(scroll_x_q), .scroll_y_q(scroll_y_q),
    .oam_addr_q(oam_addr_q), .oam_wr_stb(oam_wr_stb), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
    .vram_addr_q(vram_addr_q), .vram_rd_stb(vram_rd_stb), .vram_wr_stb(vram_wr_stb),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vblank_set(vblank_set),
    .vblank_clr(vblank_clr), .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .vblank_q(vblank_q), .nmi(nmi)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // VRAM contents seen by the bench: a fixed pattern, or 0x55 everywhere.
  bit rd_const = 1'b0;
  function automatic logic [7:0] vmem(input int a);
    return rd_const ? 8'h55 : 8'((a % 256) ^ (a / 256) ^ 'hA5);
  endfunction

  // Port observations.
  int vwr_cnt = 0, owr_cnt = 0, vrd_cnt = 0;
  int vwr_addr = 0, vwr_dat = 0, owr_addr = 0, owr_dat = 0, vrd_addr = 0;
  bit nmi_seen = 1'b0;

  always @(negedge clk) begin
    if (vram_wr_stb) begin vwr_cnt++; vwr_addr = int'(vram_addr_q); vwr_dat = int'(vram_wdata); end
    if (oam_wr_stb)  begin owr_cnt++; owr_addr = int'(oam_addr_q);  owr_dat = int'(oam_wdata);  end
    if (vram_rd_stb) begin vrd_cnt++; vrd_addr = int'(vram_addr_q); vram_rdata = vmem(int'(vram_addr_q)); end
    if (nmi) nmi_seen = 1'b1;
  end

  // Architectural model.
  int m_ctrl, m_mask, m_sx, m_sy, m_oam, m_vaddr, m_t, m_buf, m_ob;
  bit m_w, m_vbl;
  int e_vwr_cnt = 0, e_vwr_addr = 0, e_vwr_dat = 0;
  int e_owr_cnt = 0, e_owr_addr = 0, e_owr_dat = 0;
  int e_vrd_cnt = 0, e_vrd_addr = 0;

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_sx = 0; m_sy = 0; m_oam = 0; m_vaddr = 0;
    m_t = 0; m_buf = 0; m_ob = 0; m_w = 0; m_vbl = 0;
  endtask

  task automatic model_access(input int slot, input bit rw, input int d, output int ret);
    int inc;
    inc = ((m_ctrl & 4) != 0) ? 32 : 1;
    ret = m_ob;
    if (!rw) begin
      m_ob = d;
      case (slot)
        0: m_ctrl = d;
        1: m_mask = d;
        3: m_oam  = d;
        4: begin e_owr_cnt++; e_owr_addr = m_oam; e_owr_dat = d; m_oam = (m_oam + 1) % 256; end
        5: begin if (m_w) m_sy = d; else m_sx = d; m_w = !m_w; end
        6: begin
          if (!m_w) begin m_t = d % 64; m_w = 1; end
          else begin m_vaddr = (m_t * 256 + d) % 16384; m_w = 0; end
        end
        7: begin e_vwr_cnt++; e_vwr_addr = m_vaddr; e_vwr_dat = d; m_vaddr = (m_vaddr + inc) % 16384; end
        default: ;
      endcase
    end else begin
      case (slot)
        2: begin
          ret = (m_vbl ? 128 : 0) + (spr0_hit ? 64 : 0) + (spr_ovf ? 32 : 0) + (m_ob % 32);
          m_vbl = 0; m_w = 0;
        end
        4: ret = int'(oam_rdata);
        7: begin
          ret = m_buf; e_vrd_cnt++; e_vrd_addr = m_vaddr;
          m_buf = int'(vmem(m_vaddr)); m_vaddr = (m_vaddr + inc) % 16384;
        end
        default: ret = m_ob;
      endcase
      m_ob = ret;
    end
  endtask

  task automatic chk_state();
    chk("ctrl", 32'(ctrl_q), m_ctrl);
    chk("mask", 32'(mask_q), m_mask);
    chk("scroll_x", 32'(scroll_x_q), m_sx);
    chk("scroll_y", 32'(scroll_y_q), m_sy);
    chk("oam_addr", 32'(oam_addr_q), m_oam);
    chk("vram_addr", 32'(vram_addr_q), m_vaddr);
    chk("vblank", 32'(vblank_q), 32'(m_vbl));
    chk("nmi", 32'(nmi), (m_vbl && (m_ctrl & 128) != 0) ? 1 : 0);
    chk("vwr_cnt", vwr_cnt, e_vwr_cnt);
    chk("vwr_addr", vwr_addr, e_vwr_addr);
    chk("vwr_dat", vwr_dat, e_vwr_dat);
    chk("owr_cnt", owr_cnt, e_owr_cnt);
    chk("owr_addr", owr_addr, e_owr_addr);
    chk("owr_dat", owr_dat, e_owr_dat);
    chk("vrd_cnt", vrd_cnt, e_vrd_cnt);
    chk("vrd_addr", vrd_addr, e_vrd_addr);
  endtask

  // One CPU access with cs_n low for `hold` cycles; optional vblank_set in the strobe cycle.
  task automatic op(input int slot, input bit rw, input int d, input int hold, input bit race,
                    output int got);
    int exp;
    bit got_oe;
    @(negedge clk);
    cpu_addr = 3'(slot); cpu_rw = rw; cpu_wdata = 8'(d); cpu_cs_n = 1'b0;
    if (race) vblank_set = 1'b1;
    @(negedge clk);
    got = int'(cpu_rdata); got_oe = cpu_rdata_oe; vblank_set = 1'b0;
    repeat (hold - 1) @(negedge clk);
    cpu_cs_n = 1'b1;
    @(negedge clk);
    chk("oe_off", 32'(cpu_rdata_oe), 0);
    @(negedge clk);
    model_access(slot, rw, d, exp);
    if (rw) begin
      chk("rdata", got, exp);
      chk("oe_on", 32'(got_oe), 1);
    end else begin
      chk("oe_wr", 32'(got_oe), 0);
    end
    chk_state();
  endtask

  task automatic vbl_pulse(input bit set, input bit clr);
    @(negedge clk); vblank_set = set; vblank_clr = clr;
    @(negedge clk); vblank_set = 1'b0; vblank_clr = 1'b0;
    if (clr) m_vbl = 0; else if (set) m_vbl = 1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int g, n0, junk;
    reset = 1'b1; cpu_addr = '0; cpu_cs_n = 1'b1; cpu_rw = 1'b0; cpu_wdata = '0;
    oam_rdata = 8'h00; vram_rdata = 8'h00; vblank_set = 1'b0; vblank_clr = 1'b0;
    spr0_hit = 1'b0; spr_ovf = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_oe", 32'(cpu_rdata_oe), 0);
    chk("rst_strobes", {29'd0, oam_wr_stb, vram_wr_stb, vram_rd_stb}, 0);
    chk_state();

    // VRAM address setup, data write with 32-step increment.
    op(0, 0, 'h04, 1, 0, g);
    op(6, 0, 'h21, 1, 0, g);
    op(6, 0, 'h08, 1, 0, g);
    op(7, 0, 'hAA, 1, 0, g);
    chk("tp_vwr_addr", vwr_addr, 'h2108);
    chk("tp_vwr_dat", vwr_dat, 'hAA);
    chk("tp_vaddr_next", 32'(vram_addr_q), 'h2128);

    // Long chip select: one strobe, one increment.
    n0 = vwr_cnt;
    op(7, 0, 'h11, 6, 0, g);
    chk("long_cs_strobes", vwr_cnt - n0, 1);
    chk("long_cs_vaddr", 32'(vram_addr_q), 'h2148);

    // Buffered VRAM reads.
    rd_const = 1'b1;
    op(6, 0, 'h00, 1, 0, g);
    op(6, 0, 'h40, 1, 0, g);
    op(7, 1, 0, 2, 0, g);
    chk("vrd_first", g, 'h00);
    op(7, 1, 0, 1, 0, g);
    chk("vrd_second", g, 'h55);
    rd_const = 1'b0;

    // Status read clears vblank and the write toggle.
    op(5, 0, 'h12, 1, 0, g);
    vbl_pulse(1, 0);
    op(2, 1, 0, 1, 0, g);
    chk("status_vbl", g & 'hE0, 'h80);
    op(5, 0, 'h34, 1, 0, g);
    chk("scroll_after_status", 32'(scroll_x_q), 'h34);

    // Status read racing vblank_set.
    op(0, 0, 'h80, 1, 0, g);
    nmi_seen = 1'b0;
    op(2, 1, 0, 1, 1, g);
    repeat (3) @(negedge clk);
    chk("race_bit7", g & 'h80, 0);
    chk("race_nmi", 32'(nmi_seen), 0);

    // NMI enable written while vblank is already up.
    op(0, 0, 'h00, 1, 0, g);
    vbl_pulse(1, 0);
    op(0, 0, 'h80, 1, 0, g);
    chk("nmi_rise", 32'(nmi), 1);
    op(2, 1, 0, 1, 0, g);
    vbl_pulse(1, 1);

    // Open bus.
    op(0, 0, 'h3C, 1, 0, g);
    op(1, 1, 0, 1, 0, g);
    chk("openbus", g, 'h3C);
`ifdef PPU_OPEN_BUS_DECAY_EN
    repeat ((1 << DECAY_W) + 8) @(negedge clk);
    m_ob = 0;
    op(1, 1, 0, 1, 0, g);
    chk("openbus_decay", g, 0);
`endif

    // Reset mid-access: the strobe issued before reset stands, none after.
    @(negedge clk);
    cpu_addr = 3'd7; cpu_rw = 1'b0; cpu_wdata = 8'h77; cpu_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    model_access(7, 0, 'h77, junk);
    do_reset();
    repeat (4) @(negedge clk);
    chk_state();
    cpu_cs_n = 1'b1;
    op(7, 0, 'h5A, 2, 0, g);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      int slot, hold;
      bit rw;
      slot = $urandom_range(0, 7);
      rw   = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 4);
      oam_rdata = 8'($urandom);
      spr0_hit  = 1'($urandom_range(0, 1));
      spr_ovf   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
        0, 1, 2, 3: vbl_pulse(1, 0);
        4, 5:       vbl_pulse(0, 1);
        6:          vbl_pulse(1, 1);
        default:    ;
      endcase
      op(slot, rw, int'($urandom_range(0, 255)), hold, 0, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_cpu_reg_bridge.md
Name: ppu_cpu_reg_bridge

Overview:
- Clocked successor to the combinational CPU/PPU register decoder.
- Detects CPU accesses on the PPU clock and generates one strobe per access.
- Owns the architectural register file: CTRL, MASK, OAMADDR, SCROLL, VRAM address, write toggle, read buffer and open-bus latch.
- Drives the status/NMI path, sitting between the CPU bus pins and the PPU render/VRAM logic.

Parameters:
- SEL_W, 3: register-select address bits; 2**SEL_W register slots, mirrored.
- VADDR_W, 14: VRAM address width; wraps modulo 2**VADDR_W.
- DECAY_W, 22: open-bus decay counter width (optional feature only).

Ports:
- clk  in  1  PPU clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  SEL_W  register select
- cpu_cs_n  in  1  chip select, active-low
- cpu_rw  in  1  1=read, 0=write
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  registered read data
- cpu_rdata_oe  out  1  read-data drive enable
- ctrl_q  out  8  CTRL register
- mask_q  out  8  MASK register
- scroll_x_q  out  8  scroll X
- scroll_y_q  out  8  scroll Y
- oam_addr_q  out  8  OAM address
- oam_wr_stb  out  1  OAM write pulse (data = oam_wdata)
- oam_wdata  out  8  OAM write data
- oam_rdata  in  8  OAM read data at oam_addr_q
- vram_addr_q  out  VADDR_W  VRAM address
- vram_rd_stb  out  1  VRAM read request
- vram_wr_stb  out  1  VRAM write pulse
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM data, valid 1 cycle after vram_rd_stb
- vblank_set  in  1  vblank-start pulse
- vblank_clr  in  1  pre-render clear pulse (also clears the sprite flags upstream)
- spr0_hit  in  1  sprite-0 hit flag
- spr_ovf  in  1  sprite overflow flag
- vblank_q  out  1  vblank flag
- nmi  out  1  = vblank_q & ctrl_q[7]

Behaviour:
- Reset: all outputs and registers are 0; write toggle w=0; read buffer=0; open-bus latch=0; cpu_rdata_oe=0.
- Access detect: cs_n_d is a registered copy of cpu_cs_n. acc_stb = ~cpu_cs_n & cs_n_d, asserted exactly one cycle per access, however long cs_n stays low. Register effects occur only on acc_stb.
- Writes (acc_stb & ~rw) load the open-bus latch with cpu_wdata, then by slot (mirrored modulo 8):
  - 0: ctrl_q.
  - 1: mask_q.
  - 2: no effect.
  - 3: oam_addr_q.
  - 4: oam_wr_stb for one cycle, oam_wdata=cpu_wdata; oam_addr_q increments by 1 the next cycle, wrapping 0xFF->0x00.
  - 5: w=0 loads scroll_x_q; w=1 loads scroll_y_q; w toggles.
  - 6: w=0 loads t_hi = wdata[5:0] and w->1; w=1 sets vram_addr_q = {t_hi, wdata} truncated to VADDR_W, and w->0.
  - 7: vram_wr_stb for one cycle, vram_wdata=wdata at the pre-increment address; vram_addr_q then advances by 32 if ctrl_q[2] else 1, wrapping.
- Reads (acc_stb & rw): cpu_rdata is registered on the cycle after acc_stb. cpu_rdata_oe=1 from that cycle until the cycle cpu_cs_n is sampled high, then 0. The returned value also loads the open-bus latch.
  - 2 (status): returns {vblank_q, spr0_hit, spr_ovf, openbus[4:0]}; vblank_q clears and w clears.
  - 4: returns oam_rdata.
  - 7: returns the read buffer. vram_rd_stb pulses at the current address; the buffer captures vram_rdata on the following cycle; the address then increments as for writes.
  - Slots 0, 1, 3, 5, 6: return the open-bus latch.
- vblank_q: set on vblank_set, cleared on vblank_clr or status read.
  - Status read in the same cycle as vblank_set: read returns bit7=0 and vblank_q stays 0 (race suppression).
  - vblank_set and vblank_clr together: clear wins.
- Writing ctrl_q[7]=1 while vblank_q=1 raises nmi the next cycle.
- Reset mid-access: all state returns to reset values; no strobe is issued until cpu_cs_n is seen high and then low again.

Optional Feature:
- PPU_OPEN_BUS_DECAY_EN defined: a DECAY_W counter reloads on every open-bus latch update. On reaching all-ones it clears the latch to 0.
- Undefined: the latch holds its value indefinitely and the counter is not instantiated.

Decomposition:
- Package ppu_regs_pkg:
  - reg_sel_e enum (CTRL=0 .. DATA=7).
  - Status bit indices.
  - CTRL bit indices (INC32=2, NMI_EN=7).
  - Increment constants 1 and 32.
- One sub-module: ppu_access_strobe (cs_n edge detect producing acc_stb and the rdata_oe window).

Test Plan:
- Write 0x04 to slot 0; write 0x21 then 0x08 to slot 6; write 0xAA to slot 7 -> vram_wr_stb at 0x2108 with 0xAA, then vram_addr_q=0x2128.
- cs_n low for 6 cycles on a slot-7 write -> exactly one vram_wr_stb and exactly one increment.
- Slot-7 read with vram_rdata=0x55 -> first read returns the old buffer (0x00), second read returns 0x55.
- Pulse vblank_set, then read slot 2 -> returns 0x80 | openbus[4:0]; vblank_q=0 and w=0. A second write to slot 5 then loads scroll_x_q.
- Status read in the same cycle as vblank_set -> bit7=0 and nmi never rises.
- Write 0x3C to slot 0, then read slot 1 -> returns 0x3C. With PPU_OPEN_BUS_DECAY_EN, after 2**DECAY_W idle cycles a slot-1 read returns 0x00.
